pipeline_hazard_ctrl: RTL

Hazard and pipeline-sequencing controller for the 5-stage (IF/ID/EX/MEM/WB) core. It takes the decoded control word of the instruction in ID, tracks in-flight register writers in EX, MEM and WB, and generates:
- stage enables and flushes;
- load-use stalls;
- branch squashes;
- EX-stage operand forwarding selects.

It sits beside the instruction decoder and drives the pipeline-register enables and the EX operand muxes.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the core's pipeline control: result-select codes,
// forwarding-select codes and the hazard scoreboard entry.
package cpu_pkg;

  // Register address width of the 8-entry register file.
  localparam int RF_AW = 3;

  // Result-select codes carried by the decoded control word.
  localparam logic [1:0] MD_ALU  = 2'b00;
  localparam logic [1:0] MD_LOAD = 2'b01;
  localparam logic [1:0] MD_LINK = 2'b10;
  localparam logic [1:0] MD_RSVD = 2'b11;

  // EX operand source selects.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic             valid;
    logic             rw;
    logic [RF_AW-1:0] da;
    logic             load;
    logic [RF_AW-1:0] aa;
    logic [RF_AW-1:0] ba;
    logic             use_a;
    logic             use_b;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  // Source select for one EX operand. MEM is the younger writer so it wins;
  // a load in MEM has no data yet and cannot be forwarded from there.
  function automatic logic [1:0] fwd_sel(input sb_entry_t mem_e,
                                         input sb_entry_t wb_e,
                                         input logic [RF_AW-1:0] src,
                                         input logic used);
    logic [1:0] sel;
    sel = FWD_RF;
    if (used && mem_e.valid && mem_e.rw && !mem_e.load && (mem_e.da == src))
      sel = FWD_MEM;
    else if (used && wb_e.valid && wb_e.rw && (wb_e.da == src))
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc until every bit is set, then hold.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing control for the 5-stage core: pipeline enables and
// flushes, load-use stalls, branch squashes and EX operand forwarding.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_da,
  input  logic [REG_AW-1:0] id_aa,
  input  logic [REG_AW-1:0] id_ba,
  input  logic              id_rw,
  input  logic [1:0]        id_md,
  input  logic              id_ma,
  input  logic              id_mb,
  input  logic              ex_br_taken,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              pipe_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_entry_t sb_ex, sb_mem, sb_wb, id_entry;
  logic      ld_stall;
  logic      stall_inc;
  logic      flush_inc;
  logic      sb_unused;

  // Scoreboard view of the instruction currently in ID.
  always_comb begin
    id_entry       = SB_BUBBLE;
    id_entry.valid = id_valid;
    id_entry.rw    = id_rw;
    id_entry.da    = id_da;
    id_entry.load  = (id_md == MD_LOAD);
    id_entry.aa    = id_aa;
    id_entry.ba    = id_ba;
    id_entry.use_a = !id_ma;
    id_entry.use_b = !id_mb;
  end

  // A load in EX has no data until it leaves MEM, so a dependent ID
  // instruction must wait one cycle and then take it from WB.
  assign ld_stall = id_valid & sb_ex.valid & sb_ex.rw & sb_ex.load &
                    ((id_entry.use_a & (id_aa == sb_ex.da)) |
                     (id_entry.use_b & (id_ba == sb_ex.da)));

  // Priority: reset, then memory freeze, then branch squash, then load-use stall.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_en    = 1'b1;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mem_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (ex_br_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (ld_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Scoreboard shifts with the pipeline; a flushed slot enters EX as a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex  <= SB_BUBBLE;
      sb_mem <= SB_BUBBLE;
      sb_wb  <= SB_BUBBLE;
    end else if (!mem_busy) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= idex_flush ? SB_BUBBLE : id_entry;
    end
  end

  assign fwd_a = fwd_sel(sb_mem, sb_wb, sb_ex.aa, sb_ex.use_a);
  assign fwd_b = fwd_sel(sb_mem, sb_wb, sb_ex.ba, sb_ex.use_b);

  // Source fields of older stages are carried for visibility only.
  assign sb_unused = ^{sb_mem.aa, sb_mem.ba, sb_mem.use_a, sb_mem.use_b,
                       sb_wb.load, sb_wb.aa, sb_wb.ba, sb_wb.use_a, sb_wb.use_b};

  // A stall squashed by a same-cycle branch is not counted as a stall.
  assign stall_inc = !mem_busy & ld_stall & !ex_br_taken;
  assign flush_inc = !mem_busy & ex_br_taken;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule
